// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle for sync_fifo_param.
// The master drives write/read requests and the flush strobe;
// the slave (the FIFO) returns read data and status flags.
interface sync_fifo_param_if #(
    parameter int DW = 8,
    parameter int AW = 3
);
    logic          we;
    logic          re;
    logic          clr;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          dvld;
    logic          f;
    logic          e;
    logic          af;
    logic          ae;
    logic [AW:0]   cnt;
    logic          ovf;
    logic          udf;

    modport master (
        output we, re, clr, din,
        input  dout, dvld, f, e, af, ae, cnt, ovf, udf
    );

    modport slave (
        input  we, re, clr, din,
        output dout, dvld, f, e, af, ae, cnt, ovf, udf
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Parameterised single-clock FIFO with registered read data, occupancy
// count, almost-full/almost-empty thresholds and sticky overflow/underflow.
// Pointers carry an extra wrap bit so full and empty are distinguishable
// without a separate flag.
module sync_fifo_param #(
    parameter int DW     = 8,
    parameter int AW     = 3,
    parameter int AF_LVL = 6,
    parameter int AE_LVL = 2
) (
    input logic                 clk,
    input logic                 rst,
    sync_fifo_param_if.slave    bus
);
    localparam int          DEPTH = 1 << AW;
    localparam logic [AW:0] AF_C  = (AW+1)'(AF_LVL);
    localparam logic [AW:0] AE_C  = (AW+1)'(AE_LVL);

    // Storage has no reset so it can map onto block RAM.
    logic [DW-1:0] r_mem [DEPTH];

    logic [AW:0]   r_wp;
    logic [AW:0]   r_rp;
    logic [AW:0]   r_cnt;
    logic [DW-1:0] r_dout;
    logic          r_dvld;
    logic          r_ovf;
    logic          r_udf;

    logic w_full;
    logic w_empty;
    logic w_wa;
    logic w_ra;
    logic w_mem_we;

    assign w_empty = (r_wp == r_rp);
    assign w_full  = (r_wp[AW-1:0] == r_rp[AW-1:0]) && (r_wp[AW] != r_rp[AW]);

    // A write into a full FIFO is still accepted when a read frees a slot
    // in the same cycle; a read from an empty FIFO is never accepted, so
    // there is no write-to-read bypass.
    assign w_wa = bus.we && (!w_full || bus.re);
    assign w_ra = bus.re && !w_empty;

    // Reset and flush both suppress any write that cycle.
    assign w_mem_we = w_wa && !rst && !bus.clr;

    // Storage write port.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_wp[AW-1:0]] <= bus.din;
        end
    end

    // Pointers, occupancy, registered read data and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_cnt  <= '0;
            r_dout <= '0;
            r_dvld <= 1'b0;
            r_ovf  <= 1'b0;
            r_udf  <= 1'b0;
        end else if (bus.clr) begin
            // Flush: dout keeps its last value, memory is left as is.
            r_wp   <= '0;
            r_rp   <= '0;
            r_cnt  <= '0;
            r_dvld <= 1'b0;
            r_ovf  <= 1'b0;
            r_udf  <= 1'b0;
        end else begin
            r_dvld <= w_ra;
            if (w_wa) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_ra) begin
                r_rp   <= r_rp + 1'b1;
                r_dout <= r_mem[r_rp[AW-1:0]];
            end
            case ({w_wa, w_ra})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            if (bus.we && w_full && !bus.re) begin
                r_ovf <= 1'b1;
            end
            if (bus.re && w_empty) begin
                r_udf <= 1'b1;
            end
        end
    end

    assign bus.dout = r_dout;
    assign bus.dvld = r_dvld;
    assign bus.f    = w_full;
    assign bus.e    = w_empty;
    assign bus.cnt  = r_cnt;
    assign bus.af   = (r_cnt >= AF_C);
    assign bus.ae   = (r_cnt <= AE_C);
    assign bus.ovf  = r_ovf;
    assign bus.udf  = r_udf;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (DW=8, AW=3, AF=6, AE=2).
// A queue-based reference model predicts every output after each edge;
// directed steps cover the documented scenarios, then a random phase follows.
module tb_sync_fifo_param;
    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic clk;
    logic rst;

    sync_fifo_param_if #(.DW(DW), .AW(AW)) bus_if ();

    sync_fifo_param #(.DW(DW), .AW(AW), .AF_LVL(6), .AE_LVL(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [DW-1:0] mq [$];
    logic [DW-1:0] m_dout;
    logic          m_dvld;
    logic          m_ovf;
    logic          m_udf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic w, input logic r, input logic c,
                              input logic rs, input logic [DW-1:0] d);
        int sz;
        sz = mq.size();
        if (rs) begin
            mq.delete();
            m_dout = '0; m_dvld = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
        end else if (c) begin
            mq.delete();
            m_dvld = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
        end else begin
            m_dvld = 1'b0;
            if (w && sz == DEPTH && !r) m_ovf = 1'b1;
            if (r && sz == 0)           m_udf = 1'b1;
            if (r && sz > 0) begin
                m_dout = mq.pop_front();
                m_dvld = 1'b1;
            end
            if (w && (sz < DEPTH || r)) mq.push_back(d);
        end
    endtask

    task automatic check_all(input string tag);
        int sz;
        sz = mq.size();
        chk({tag, ".cnt"},  64'(bus_if.cnt),  64'(sz));
        chk({tag, ".e"},    64'(bus_if.e),    64'(sz == 0));
        chk({tag, ".f"},    64'(bus_if.f),    64'(sz == DEPTH));
        chk({tag, ".af"},   64'(bus_if.af),   64'(sz >= 6));
        chk({tag, ".ae"},   64'(bus_if.ae),   64'(sz <= 2));
        chk({tag, ".dout"}, 64'(bus_if.dout), 64'(m_dout));
        chk({tag, ".dvld"}, 64'(bus_if.dvld), 64'(m_dvld));
        chk({tag, ".ovf"},  64'(bus_if.ovf),  64'(m_ovf));
        chk({tag, ".udf"},  64'(bus_if.udf),  64'(m_udf));
    endtask

    // One clock: drive, edge, advance the model, sample 1ns later.
    task automatic cyc(input string tag, input logic w, input logic r, input logic c,
                       input logic rs, input logic [DW-1:0] d);
        rst        = rs;
        bus_if.we  = w;
        bus_if.re  = r;
        bus_if.clr = c;
        bus_if.din = d;
        @(posedge clk);
        model_step(w, r, c, rs, d);
        #1;
        check_all(tag);
        $display("[TB] %s we=%0b re=%0b clr=%0b rst=%0b din=%02h -> cnt=%0d dout=%02h dvld=%0b",
                 tag, w, r, c, rs, d, bus_if.cnt, bus_if.dout, bus_if.dvld);
    endtask

    initial begin
        rst = 1'b1; bus_if.we = 1'b0; bus_if.re = 1'b0; bus_if.clr = 1'b0; bus_if.din = '0;
        mq.delete(); m_dout = '0; m_dvld = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;

        // Reset state
        cyc("reset", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("reset.e_const", 64'(bus_if.e), 64'd1);
        chk("reset.ae_const", 64'(bus_if.ae), 64'd1);
        cyc("idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // Fill with 1..8
        for (int i = 1; i <= 8; i++) begin
            cyc("fill", 1'b1, 1'b0, 1'b0, 1'b0, 8'(i));
            chk("fill.cnt_step", 64'(bus_if.cnt), 64'(i));
            chk("fill.ae_edge", 64'(bus_if.ae), (i >= 3) ? 64'd0 : 64'd1);
            chk("fill.af_edge", 64'(bus_if.af), (i >= 6) ? 64'd1 : 64'd0);
        end
        chk("fill.f_const", 64'(bus_if.f), 64'd1);
        chk("fill.ovf_const", 64'(bus_if.ovf), 64'd0);

        // Overflow attempt
        cyc("ovf_wr", 1'b1, 1'b0, 1'b0, 1'b0, 8'd9);
        chk("ovf.flag", 64'(bus_if.ovf), 64'd1);
        chk("ovf.cnt", 64'(bus_if.cnt), 64'd8);

        // Drain 1..8
        for (int i = 1; i <= 8; i++) begin
            cyc("drain", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            chk("drain.dout", 64'(bus_if.dout), 64'(i));
            chk("drain.dvld", 64'(bus_if.dvld), 64'd1);
            cyc("drain_gap", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
            chk("drain.dvld_drop", 64'(bus_if.dvld), 64'd0);
        end
        chk("drain.e_const", 64'(bus_if.e), 64'd1);

        // Underflow, then flush
        cyc("udf_rd", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("udf.flag", 64'(bus_if.udf), 64'd1);
        chk("udf.dout_hold", 64'(bus_if.dout), 64'd8);
        chk("udf.dvld", 64'(bus_if.dvld), 64'd0);
        cyc("clr", 1'b1, 1'b1, 1'b1, 1'b0, 8'hEE);
        chk("clr.ovf", 64'(bus_if.ovf), 64'd0);
        chk("clr.udf", 64'(bus_if.udf), 64'd0);
        chk("clr.cnt", 64'(bus_if.cnt), 64'd0);

        // Full FIFO with simultaneous read/write
        for (int i = 1; i <= 8; i++) cyc("refill", 1'b1, 1'b0, 1'b0, 1'b0, 8'(i));
        for (int i = 0; i < 4; i++) begin
            cyc("full_rw", 1'b1, 1'b1, 1'b0, 1'b0, 8'(20 + i));
            chk("full_rw.cnt", 64'(bus_if.cnt), 64'd8);
            chk("full_rw.f", 64'(bus_if.f), 64'd1);
            chk("full_rw.dout", 64'(bus_if.dout), 64'(i + 1));
        end
        begin
            logic [7:0] exp_seq [8];
            exp_seq = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd20, 8'd21, 8'd22, 8'd23};
            for (int i = 0; i < 8; i++) begin
                cyc("full_drain", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
                chk("full_drain.dout", 64'(bus_if.dout), 64'(exp_seq[i]));
            end
        end

        // Empty FIFO with simultaneous read/write: no bypass
        cyc("empty_rw", 1'b1, 1'b1, 1'b0, 1'b0, 8'h55);
        chk("empty_rw.cnt", 64'(bus_if.cnt), 64'd1);
        chk("empty_rw.dvld", 64'(bus_if.dvld), 64'd0);
        chk("empty_rw.udf", 64'(bus_if.udf), 64'd1);
        cyc("empty_rw_rd", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("empty_rw_rd.dout", 64'(bus_if.dout), 64'h55);

        // Reset mid-transfer after wrapped pointers
        cyc("pre_clr", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) cyc("w5", 1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h30 + i));
        for (int i = 0; i < 20; i++) cyc("wrap", 1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
        cyc("mid_rst", 1'b1, 1'b1, 1'b0, 1'b1, 8'hAA);
        chk("mid_rst.cnt", 64'(bus_if.cnt), 64'd0);
        chk("mid_rst.dout", 64'(bus_if.dout), 64'd0);
        chk("mid_rst.e", 64'(bus_if.e), 64'd1);
        cyc("post_rst_wr", 1'b1, 1'b0, 1'b0, 1'b0, 8'hA7);
        cyc("post_rst_rd", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("post_rst.dout", 64'(bus_if.dout), 64'hA7);

        // Random phase against the model
        for (int i = 0; i < 400; i++) begin
            logic w, r, c, rs;
            w  = ($urandom_range(0, 99) < 55);
            r  = ($urandom_range(0, 99) < 45);
            c  = ($urandom_range(0, 99) < 3);
            rs = ($urandom_range(0, 99) < 2);
            cyc("rand", w, r, c, rs, 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
